sigmoid_arbiter: RTL

Shares one sigmoid activation unit among N neuron requesters. The block grants the unit to one requester at a time and routes that requester's argument, result, error and propagate handshakes to and from the unit. In training mode the grant covers the whole forward and backward transaction. It sits between the neuron array and a single activation instance, so the neurons need only one lookup table.

---
 rtl/sigmoid_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter
//   Lets N neuron requesters share one sigmoid activation unit. One requester
//   at a time owns the unit. Its argument, result, error and propagate
//   handshakes are routed to and from the unit combinationally. In training
//   mode the grant covers the whole forward and backward transaction.
//
// Build option:
//   SIGMOID_ARBITER_ROUND_ROBIN_EN  defined   -> round-robin arbitration
//                                   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clock, reset          rising-edge clock; synchronous active-low reset
//   train                 training mode, sampled when the grant is taken
//   req_argument_*        per-requester argument channel (16-bit slice i = requester i)
//   req_result_*          per-requester result valid/ready; data broadcast (8 bits)
//   req_error_*           per-requester error channel (16-bit slice i = requester i)
//   req_propagate_*       per-requester propagate valid/ready; data broadcast (16 bits)
//   act_train             latched train bit for the activation unit
//   act_argument/result/error/propagate_*  single channel set to the unit
//   grant                 index of the current owner
//   busy                  high whenever a transaction is in progress
//
// States:
//   IDLE | no owner; arbitrate among pending argument valids
//   ARG  | owner's argument channel routed to the unit
//   RES  | unit's result routed back to the owner
//   ERR  | owner's error channel routed to the unit (training only)
//   PRP  | unit's propagate value routed back to the owner (training only)

module sigmoid_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            train,

    input  logic [N-1:0]    req_argument_valid,
    input  logic [16*N-1:0] req_argument_data,
    output logic [N-1:0]    req_argument_ready,

    output logic [N-1:0]    req_result_valid,
    output logic [7:0]      req_result_data,
    input  logic [N-1:0]    req_result_ready,

    input  logic [N-1:0]    req_error_valid,
    input  logic [16*N-1:0] req_error_data,
    output logic [N-1:0]    req_error_ready,

    output logic [N-1:0]    req_propagate_valid,
    output logic [15:0]     req_propagate_data,
    input  logic [N-1:0]    req_propagate_ready,

    output logic            act_train,

    output logic            act_argument_valid,
    output logic [15:0]     act_argument_data,
    input  logic            act_argument_ready,

    input  logic            act_result_valid,
    input  logic [7:0]      act_result_data,
    output logic            act_result_ready,

    output logic            act_error_valid,
    output logic [15:0]     act_error_data,
    input  logic            act_error_ready,

    input  logic            act_propagate_valid,
    input  logic [15:0]     act_propagate_data,
    output logic            act_propagate_ready,

    output logic [W-1:0]    grant,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG  = 3'd1,
        RES  = 3'd2,
        ERR  = 3'd3,
        PRP  = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   winner;
    logic [N-1:0]   gnt_oh;
    logic [15:0]    arg_sel;
    logic [15:0]    err_sel;
    logic           take_grant;

    assign take_grant = (state == IDLE) && (|req_argument_valid);
    assign busy       = (state != IDLE);

`ifdef SIGMOID_ARBITER_ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;
    int           dist;
    int           best_dist;

    // The requester with the smallest distance after the pointer wins, which
    // is the same as searching from pointer+1 and wrapping at N-1.
    always_comb begin
        winner    = '0;
        dist      = 0;
        best_dist = N;
        for (int i = 0; i < N; i++) begin
            dist = (i + N - 1 - int'(rr_ptr)) % N;
            if (req_argument_valid[i] && (dist < best_dist)) begin
                best_dist = dist;
                winner    = W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= W'(N - 1);
        end else if (take_grant) begin
            rr_ptr <= winner;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_argument_valid[i]) begin
                winner = W'(i);
            end
        end
    end
`endif

    // One-hot view of the owner plus its argument/error data slices.
    always_comb begin
        gnt_oh  = '0;
        arg_sel = '0;
        err_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == W'(i)) begin
                gnt_oh[i] = 1'b1;
                arg_sel   = req_argument_data[16*i +: 16];
                err_sel   = req_error_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            act_train <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_grant) begin
                grant     <= winner;
                act_train <= train;
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        req_argument_ready  = '0;
        req_result_valid    = '0;
        req_error_ready     = '0;
        req_propagate_valid = '0;
        act_argument_valid  = 1'b0;
        act_result_ready    = 1'b0;
        act_error_valid     = 1'b0;
        act_propagate_ready = 1'b0;
        act_argument_data   = arg_sel;
        act_error_data      = err_sel;
        req_result_data     = act_result_data;
        req_propagate_data  = act_propagate_data;

        case (state)
            IDLE: begin
                if (|req_argument_valid) begin
                    state_nxt = ARG;
                end
            end
            ARG: begin
                act_argument_valid = |(req_argument_valid & gnt_oh);
                req_argument_ready = gnt_oh & {N{act_argument_ready}};
                if (act_argument_valid && act_argument_ready) begin
                    state_nxt = RES;
                end
            end
            RES: begin
                req_result_valid = gnt_oh & {N{act_result_valid}};
                act_result_ready = |(req_result_ready & gnt_oh);
                if (act_result_valid && act_result_ready) begin
                    state_nxt = act_train ? ERR : IDLE;
                end
            end
            ERR: begin
                act_error_valid = |(req_error_valid & gnt_oh);
                req_error_ready = gnt_oh & {N{act_error_ready}};
                if (act_error_valid && act_error_ready) begin
                    state_nxt = PRP;
                end
            end
            PRP: begin
                req_propagate_valid = gnt_oh & {N{act_propagate_valid}};
                act_propagate_ready = |(req_propagate_ready & gnt_oh);
                if (act_propagate_valid && act_propagate_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
